// File: rtl/rw_txn_ctrl.sv
// rw_txn_ctrl: turns one page read/write request into the four-message
// token/data sequence for protocolFSM and reports a single done pulse.
module rw_txn_ctrl #(
    parameter logic [3:0] ADDR_ENDP   = 4'd4,
    parameter logic [3:0] DATA_ENDP   = 4'd8,
    parameter int         WDOG_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_write,
    input  logic        start_read,
    input  logic [15:0] mem_page,
    input  logic [63:0] data_write,
    output logic [2:0]  msg_type,
    output logic [3:0]  endp,
    output logic [63:0] protocol_din,
    input  logic        protocol_free,
    input  logic        timeout,
    input  logic [63:0] protocol_dout,
    output logic [63:0] rw_data_read,
    output logic        rw_done,
    output logic        read_success,
    output logic        write_success,
    output logic        busy
);
    localparam logic [2:0] MSG_NONE     = 3'b000;
    localparam logic [2:0] MSG_IN_TOK   = 3'b001;
    localparam logic [2:0] MSG_OUT_TOK  = 3'b010;
    localparam logic [2:0] MSG_OUT_DATA = 3'b011;
    localparam logic [2:0] MSG_IN_DATA  = 3'b100;

    localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_FREE, DONE} state_t;

    state_t            state;
    logic [1:0]        step;
    logic              op_write;
    logic [15:0]       page_q;
    logic [63:0]       wdata_q;
    logic [WDOG_W-1:0] wdog;
    logic              wdog_expired;
    logic              fail;

    function automatic logic [2:0] step_msg(input logic is_write, input logic [1:0] s);
        case (s)
            2'd0:    step_msg = MSG_OUT_TOK;
            2'd1:    step_msg = MSG_OUT_DATA;
            2'd2:    step_msg = is_write ? MSG_OUT_TOK : MSG_IN_TOK;
            default: step_msg = is_write ? MSG_OUT_DATA : MSG_IN_DATA;
        endcase
    endfunction

    // Steps 0-1 move the page address, steps 2-3 move the data.
    function automatic logic [3:0] step_endp(input logic [1:0] s);
        step_endp = s[1] ? DATA_ENDP : ADDR_ENDP;
    endfunction

    function automatic logic [63:0] step_din(input logic [1:0] s, input logic [15:0] page,
                                             input logic [63:0] wdata);
        step_din = s[1] ? wdata : {48'b0, page};
    endfunction

    assign wdog_expired = (wdog == WDOG_LAST);

    // Protocol timeout beats a simultaneous protocol_free rise.
    always_comb begin
        fail = 1'b0;
        if (state == WAIT_BUSY || state == WAIT_FREE)
            fail = timeout || wdog_expired;
        else if (state == ISSUE)
            fail = wdog_expired && !protocol_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            step          <= '0;
            wdog          <= '0;
            op_write      <= 1'b0;
            msg_type      <= MSG_NONE;
            endp          <= '0;
            protocol_din  <= '0;
            rw_data_read  <= '0;
            rw_done       <= 1'b0;
            read_success  <= 1'b0;
            write_success <= 1'b0;
            busy          <= 1'b0;
        end else begin
            msg_type      <= MSG_NONE;
            rw_done       <= 1'b0;
            read_success  <= 1'b0;
            write_success <= 1'b0;
            if (fail) begin
                rw_done <= 1'b1;
                state   <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_write || start_read) begin
                            op_write <= start_write;
                            page_q   <= mem_page;
                            wdata_q  <= data_write;
                            step     <= '0;
                            wdog     <= '0;
                            busy     <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (protocol_free) begin
                            msg_type     <= step_msg(op_write, step);
                            endp         <= step_endp(step);
                            protocol_din <= step_din(step, page_q, wdata_q);
                            wdog         <= '0;
                            state        <= WAIT_BUSY;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    WAIT_BUSY: begin
                        wdog <= wdog + 1'b1;
                        if (!protocol_free)
                            state <= WAIT_FREE;
                    end
                    WAIT_FREE: begin
                        if (protocol_free) begin
                            if (step == 2'd3) begin
                                if (!op_write)
                                    rw_data_read <= protocol_dout;
                                rw_done       <= 1'b1;
                                write_success <= op_write;
                                read_success  <= !op_write;
                                state         <= DONE;
                            end else begin
                                step  <= step + 1'b1;
                                wdog  <= '0;
                                state <= ISSUE;
                            end
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rw_txn_ctrl.sv
// Bench for rw_txn_ctrl: a responder emulates protocolFSM while a
// transaction-level model predicts messages, done timing and captured data.
`timescale 1ns/1ps
module tb_rw_txn_ctrl;
    localparam int         WDOG = 4096;
    localparam logic [3:0] AE   = 4'd4;
    localparam logic [3:0] DE   = 4'd8;

    logic        clk = 1'b0;
    logic        rst, start_write, start_read, protocol_free, timeout;
    logic [15:0] mem_page;
    logic [63:0] data_write, protocol_dout;
    logic [2:0]  msg_type;
    logic [3:0]  endp;
    logic [63:0] protocol_din, rw_data_read;
    logic        rw_done, read_success, write_success, busy;

    rw_txn_ctrl #(.ADDR_ENDP(AE), .DATA_ENDP(DE), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .start_write(start_write), .start_read(start_read),
        .mem_page(mem_page), .data_write(data_write), .msg_type(msg_type), .endp(endp),
        .protocol_din(protocol_din), .protocol_free(protocol_free), .timeout(timeout),
        .protocol_dout(protocol_dout), .rw_data_read(rw_data_read), .rw_done(rw_done),
        .read_success(read_success), .write_success(write_success), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  t;
        logic [3:0]  e;
        logic [63:0] d;
    } msg_t;

    msg_t        exp_q[$];
    msg_t        cm;
    logic [2:0]  obs_t[$];
    logic [3:0]  obs_e[$];
    logic [63:0] obs_d[$];
    int          obs_c[$];
    int          exp_done_cyc = -10;
    bit          exp_ws = 1'b0, exp_rs = 1'b0;
    int          busy_from = 1 << 30, busy_until = -1;
    int          rd_pend_cyc = -1;
    logic [63:0] rd_pend_val = '0, exp_rd = '0;
    bit          chk_en = 1'b0;
    int          done_cnt = 0, ws_cnt = 0, rs_cnt = 0, last_done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void push_seq(input bit wr, input logic [15:0] pg, input logic [63:0] wd);
        exp_q.push_back('{3'b010, AE, {48'b0, pg}});
        exp_q.push_back('{3'b011, AE, {48'b0, pg}});
        if (wr) begin
            exp_q.push_back('{3'b010, DE, 64'd0});
            exp_q.push_back('{3'b011, DE, wd});
        end else begin
            exp_q.push_back('{3'b001, DE, 64'd0});
            exp_q.push_back('{3'b100, DE, 64'd0});
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            if (cyc == rd_pend_cyc) exp_rd = rd_pend_val;
            chk("rw_data_read", rw_data_read, exp_rd);
            chk("busy", {63'd0, busy}, {63'd0, (cyc >= busy_from && cyc <= busy_until)});
            if (msg_type != 3'b000) begin
                obs_t.push_back(msg_type);
                obs_e.push_back(endp);
                obs_d.push_back(protocol_din);
                obs_c.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_msg", {61'd0, msg_type}, 64'd0);
                end else begin
                    cm = exp_q.pop_front();
                    chk("msg_type", {61'd0, msg_type}, {61'd0, cm.t});
                    chk("endp", {60'd0, endp}, {60'd0, cm.e});
                    if (cm.t == 3'b011) chk("protocol_din", protocol_din, cm.d);
                end
            end
            if (rw_done || cyc == exp_done_cyc) begin
                chk("rw_done", {63'd0, rw_done}, {63'd0, (cyc == exp_done_cyc)});
                chk("write_success", {63'd0, write_success}, {63'd0, exp_ws});
                chk("read_success", {63'd0, read_success}, {63'd0, exp_rs});
                if (rw_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (write_success) ws_cnt++;
                    if (read_success) rs_cnt++;
                end
            end else begin
                chk("flags_quiet", {62'd0, read_success, write_success}, 64'd0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_msg_type"}, {61'd0, msg_type}, 64'd0);
        chk({tag, "_endp"}, {60'd0, endp}, 64'd0);
        chk({tag, "_din"}, protocol_din, 64'd0);
        chk({tag, "_rd"}, rw_data_read, 64'd0);
        chk({tag, "_done"}, {63'd0, rw_done}, 64'd0);
        chk({tag, "_flags"}, {62'd0, read_success, write_success}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // One transaction: drive the start, then act as protocolFSM every cycle.
    task automatic do_txn(input bit wr, input bit rd, input logic [15:0] pg,
                          input logic [63:0] wd, input logic [63:0] rdata, input int bcyc,
                          input int to_step, input int to_dly, input bit wdog_test,
                          input int extra_step, input int rst_step);
        int nmsg, rem, k;
        bit active, fin, out_data;
        logic [63:0] last_d;
        nmsg = 0; rem = 0; k = 0; active = 0; fin = 0; out_data = 0; last_d = '0;
        @(negedge clk);
        while (cyc <= exp_done_cyc && k < 100) begin
            @(negedge clk);
            k++;
        end
        start_write = wr; start_read = rd; mem_page = pg; data_write = wd;
        busy_from = cyc + 1; busy_until = 1 << 30; exp_done_cyc = 1 << 30;
        exp_ws = wr; exp_rs = !wr;
        push_seq(wr, pg, wd);
        for (k = 0; k < 6000 && !fin; k++) begin
            @(negedge clk);
            start_write = 0; start_read = 0; timeout = 0;
            mem_page = 16'($urandom); data_write = {$urandom, $urandom};
            protocol_dout = {$urandom, $urandom};
            if (cyc == exp_done_cyc) begin
                fin = 1; protocol_free = 1;
            end else if (msg_type != 3'b000) begin
                nmsg++; active = 1; rem = bcyc; protocol_free = 0;
                out_data = (nmsg == 2) || (nmsg == 4 && wr);
                last_d = (nmsg == 2) ? {48'b0, pg} : wd;
                if (wdog_test) begin
                    exp_done_cyc = cyc + WDOG; busy_until = exp_done_cyc;
                    exp_ws = 0; exp_rs = 0; exp_q.delete(); rem = 1 << 30;
                end
                if (nmsg - 1 == extra_step) start_read = 1;
            end else if (active) begin
                if (out_data) chk("din_hold", protocol_din, last_d);
                rem--;
                if (rst_step == nmsg - 1 && rem == bcyc - 3) begin
                    rst = 1; exp_q.delete(); busy_until = cyc; exp_done_cyc = -1;
                    rd_pend_val = '0; rd_pend_cyc = cyc + 1;
                    @(negedge clk);
                    rst = 0; protocol_free = 1;
                    check_reset_values("mid_reset");
                    fin = 1; active = 0;
                end else if (to_step == nmsg - 1 && (bcyc - rem) == to_dly) begin
                    timeout = 1; protocol_free = (rem == 0);
                    exp_done_cyc = cyc + 1; busy_until = cyc + 1;
                    exp_ws = 0; exp_rs = 0; exp_q.delete(); active = 0;
                end else if (rem == 0) begin
                    protocol_free = 1; active = 0;
                    if (nmsg == 4) begin
                        exp_done_cyc = cyc + 1; busy_until = cyc + 1;
                        if (!wr) begin
                            protocol_dout = rdata;
                            rd_pend_val = rdata; rd_pend_cyc = cyc + 1;
                        end
                    end
                end
            end
        end
        chk("txn_complete", {63'd0, fin}, 64'd1);
        chk("msgs_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic clear_obs();
        obs_t.delete(); obs_e.delete(); obs_d.delete(); obs_c.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [2:0] wseq[4];
        logic [2:0] rseq[4];
        logic [3:0] eseq[4];
        int d0, w0, r0, n_in_data;
        wseq = '{3'b010, 3'b011, 3'b010, 3'b011};
        rseq = '{3'b010, 3'b011, 3'b001, 3'b100};
        eseq = '{4'd4, 4'd4, 4'd8, 4'd8};
        rst = 1; start_write = 0; start_read = 0; mem_page = '0; data_write = '0;
        protocol_free = 1; timeout = 0; protocol_dout = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 0;
        chk_en = 1;

        // Directed write
        clear_obs(); d0 = done_cnt; w0 = ws_cnt;
        do_txn(1, 0, 16'h00A5, 64'hDEAD_BEEF_0123_4567, 64'd0, 10, -1, 1, 0, -1, -1);
        chk("wr_msg_count", 64'(obs_t.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_seq_type", {61'd0, obs_t[i]}, {61'd0, wseq[i]});
            chk("wr_seq_endp", {60'd0, obs_e[i]}, {60'd0, eseq[i]});
        end
        chk("wr_din_page", obs_d[1], 64'h00A5);
        chk("wr_din_data", obs_d[3], 64'hDEAD_BEEF_0123_4567);
        chk("wr_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("wr_success_pulses", 64'(ws_cnt - w0), 64'd1);

        // Directed read
        clear_obs(); d0 = done_cnt; r0 = rs_cnt;
        do_txn(0, 1, 16'h1234, 64'd0, 64'hF77DB57B7D5D7F53, 10, -1, 1, 0, -1, -1);
        for (int i = 0; i < 4; i++)
            chk("rd_seq_type", {61'd0, obs_t[i]}, {61'd0, rseq[i]});
        chk("rd_din_page", obs_d[1], 64'h1234);
        chk("rd_data", rw_data_read, 64'hF77DB57B7D5D7F53);
        chk("rd_success_pulses", 64'(rs_cnt - r0), 64'd1);

        // Read with timeout during IN_TOK
        clear_obs(); d0 = done_cnt; w0 = ws_cnt; r0 = rs_cnt;
        do_txn(0, 1, 16'h0042, 64'd0, 64'h1111_2222_3333_4444, 6, 2, 2, 0, -1, -1);
        n_in_data = 0;
        foreach (obs_t[i]) if (obs_t[i] == 3'b100) n_in_data++;
        chk("to_msg_count", 64'(obs_t.size()), 64'd3);
        chk("to_no_in_data", 64'(n_in_data), 64'd0);
        chk("to_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("to_no_success", 64'((ws_cnt - w0) + (rs_cnt - r0)), 64'd0);
        chk("to_rd_kept", rw_data_read, 64'hF77DB57B7D5D7F53);

        // protocol_free stuck low after the first issue
        clear_obs(); d0 = done_cnt;
        do_txn(1, 0, 16'h0101, 64'h0BAD_F00D, 64'd0, 3, -1, 1, 1, -1, -1);
        chk("wdog_msg_count", 64'(obs_t.size()), 64'd1);
        chk("wdog_latency", 64'(last_done_cyc - obs_c[0]), 64'd4096);
        chk("wdog_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Simultaneous starts, then a stray start_read mid-transaction
        clear_obs(); d0 = done_cnt; w0 = ws_cnt;
        do_txn(1, 1, 16'h0F0F, 64'h0123_4567_89AB_CDEF, 64'd0, 3, -1, 1, 0, 1, -1);
        repeat (6) @(negedge clk);
        chk("both_msg_count", 64'(obs_t.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("both_seq_type", {61'd0, obs_t[i]}, {61'd0, wseq[i]});
        chk("both_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("both_write_success", 64'(ws_cnt - w0), 64'd1);

        // Reset during step 1 WAIT_FREE, then a clean read
        d0 = done_cnt;
        do_txn(0, 1, 16'h0077, 64'd0, 64'h9999_8888_7777_6666, 10, -1, 1, 0, -1, 1);
        repeat (4) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        do_txn(0, 1, 16'h0088, 64'd0, 64'hA5A5_5A5A_C3C3_3C3C, 2, -1, 1, 0, -1, -1);
        chk("post_rst_rd", rw_data_read, 64'hA5A5_5A5A_C3C3_3C3C);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int r, bc, ts, td, ex;
            bit w, rr;
            r  = $urandom_range(0, 9);
            w  = (r < 4) || (r == 9);
            rr = (r >= 4);
            bc = $urandom_range(1, 5);
            ts = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            td = $urandom_range(1, bc);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            do_txn(w, rr, 16'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   bc, ts, td, 0, ex, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
